// File: rtl/aes_job_sequencer.sv
// -----------------------------------------------------------------------------
// aes_job_sequencer
//
// Purpose:
//   Runs one AES-128 encryption job at a time on a picoaes peripheral over a
//   simple single-cycle register bus. A job (key + plaintext) is accepted,
//   the key, plaintext and control registers are written, the status
//   register is polled for "done", the ciphertext is read back and the
//   result is held until the consumer takes it. If "done" never arrives
//   within POLL_LIMIT polls, the job is aborted and reported with res_err=1
//   and a zero ciphertext.
//
// Parameters:
//   POLL_LIMIT  maximum number of STATUS polls before a job is aborted
//
// Ports:
//   clk          single clock, rising edge
//   resetn       asynchronous active-low reset
//   job_valid    job request            job_ready   job accept (IDLE only)
//   job_key      128-bit AES key        job_pt      128-bit plaintext
//   res_valid    result available       res_ready   result consumed
//   res_ct       128-bit ciphertext     res_err     poll timeout occurred
//   m_valid      bus access strobe      m_wen       write enable
//   m_addr       7-bit byte address     m_wdata     32-bit write data
//   m_rdata      32-bit read data, combinational in the m_addr cycle
//   dbg_state_o  current FSM state (encoding of state_t)
//
// Optional feature (compile-time macro AES_SEQ_KEYCACHE_EN):
//   Remembers the last fully written key. A job whose key matches a valid
//   cached key skips the key writes and starts at the plaintext writes.
//   The cache is invalidated on reset and on poll timeout. Without the
//   macro, no cache storage exists and every job writes the key.
//
// Handshakes (job_* and res_*): a transfer happens on a rising clock edge
// where valid and ready are both high. The requester holds valid (and its
// payload) until that edge; the responder may raise or drop ready freely.
// res_valid, once high, stays high with stable res_ct/res_err until taken.
// -----------------------------------------------------------------------------
module aes_job_sequencer #(
    parameter int POLL_LIMIT = 1024
) (
    input  logic         clk,
    input  logic         resetn,
    // job request
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [127:0] job_key,
    input  logic [127:0] job_pt,
    // result
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_ct,
    output logic         res_err,
    // picoaes register bus
    output logic         m_valid,
    output logic         m_wen,
    output logic [6:0]   m_addr,
    output logic [31:0]  m_wdata,
    input  logic [31:0]  m_rdata,
    // debug
    output logic [2:0]   dbg_state_o
);

    // Poll counter must be able to hold POLL_LIMIT-1.
    localparam int CNT_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_LIMIT - 1);

    // picoaes register map (byte addresses)
    localparam logic [6:0] ADDR_CTRL    = 7'h00;
    localparam logic [6:0] ADDR_KEY_LO  = 7'h10; // key[31:0], next words step down by 4
    localparam logic [6:0] ADDR_PT_LO   = 7'h20; // pt[31:0],  next words step down by 4
    localparam logic [6:0] ADDR_CT_LO   = 7'h40; // ct[31:0],  next words step down by 4
    localparam logic [6:0] ADDR_STATUS  = 7'h44;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WKEY  = 3'd1,
        WPT   = 3'd2,
        WCTRL = 3'd3,
        POLL  = 3'd4,
        RDCT  = 3'd5,
        RESP  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       beat_q, beat_d;      // word index within a 4-beat phase
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     pt_q, pt_d;
    logic [127:0]     ct_q, ct_d;
    logic             err_q, err_d;

`ifdef AES_SEQ_KEYCACHE_EN
    logic [127:0]     kc_key_q, kc_key_d;
    logic             kc_vld_q, kc_vld_d;
`endif

    // Byte offset of the current word: words are laid out from the
    // low-order word downward in address, 4 bytes apart.
    logic [6:0] beat_ofs;
    logic [6:0] word_lsb;
    assign beat_ofs = {3'b000, beat_q, 2'b00};
    assign word_lsb = {beat_q, 5'b00000};

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            beat_q     <= 2'd0;
            poll_cnt_q <= '0;
            key_q      <= '0;
            pt_q       <= '0;
            ct_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            poll_cnt_q <= poll_cnt_d;
            key_q      <= key_d;
            pt_q       <= pt_d;
            ct_q       <= ct_d;
            err_q      <= err_d;
        end
    end

`ifdef AES_SEQ_KEYCACHE_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            kc_key_q <= '0;
            kc_vld_q <= 1'b0;
        end else begin
            kc_key_q <= kc_key_d;
            kc_vld_q <= kc_vld_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and bus outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        poll_cnt_d = poll_cnt_q;
        key_d      = key_q;
        pt_d       = pt_q;
        ct_d       = ct_q;
        err_d      = err_q;
`ifdef AES_SEQ_KEYCACHE_EN
        kc_key_d   = kc_key_q;
        kc_vld_d   = kc_vld_q;
`endif
        job_ready  = 1'b0;
        res_valid  = 1'b0;
        m_valid    = 1'b0;
        m_wen      = 1'b0;
        m_addr     = 7'h00;
        m_wdata    = 32'h0;

        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    key_d      = job_key;
                    pt_d       = job_pt;
                    err_d      = 1'b0;
                    beat_d     = 2'd0;
                    poll_cnt_d = '0;
`ifdef AES_SEQ_KEYCACHE_EN
                    // The peripheral still holds this key from an earlier
                    // complete key write, so the key phase can be skipped.
                    if (kc_vld_q && (job_key == kc_key_q)) begin
                        state_d = WPT;
                    end else begin
                        state_d = WKEY;
                    end
`else
                    state_d = WKEY;
`endif
                end
            end

            WKEY: begin
                m_valid = 1'b1;
                m_wen   = 1'b1;
                m_addr  = ADDR_KEY_LO - beat_ofs;
                m_wdata = key_q[word_lsb +: 32];
                beat_d  = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = WPT;
`ifdef AES_SEQ_KEYCACHE_EN
                    // Cache only once all four key words are in the peripheral.
                    kc_key_d = key_q;
                    kc_vld_d = 1'b1;
`endif
                end
            end

            WPT: begin
                m_valid = 1'b1;
                m_wen   = 1'b1;
                m_addr  = ADDR_PT_LO - beat_ofs;
                m_wdata = pt_q[word_lsb +: 32];
                beat_d  = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = WCTRL;
                end
            end

            WCTRL: begin
                // Control sequence 0x6, 0x6, 0x4, 0x4 starts the encryption.
                m_valid = 1'b1;
                m_wen   = 1'b1;
                m_addr  = ADDR_CTRL;
                m_wdata = beat_q[1] ? 32'h4 : 32'h6;
                beat_d  = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = POLL;
                end
            end

            POLL: begin
                m_valid = 1'b1;
                m_addr  = ADDR_STATUS;
                if (m_rdata[0]) begin
                    beat_d  = 2'd0;
                    state_d = RDCT;
                end else if (poll_cnt_q == POLL_LAST) begin
                    // This was the last allowed poll: abort the job.
                    ct_d    = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
`ifdef AES_SEQ_KEYCACHE_EN
                    kc_vld_d = 1'b0;
`endif
                end else begin
                    poll_cnt_d = poll_cnt_q + CNT_W'(1);
                end
            end

            RDCT: begin
                m_valid = 1'b1;
                m_addr  = ADDR_CT_LO - beat_ofs;
                ct_d[word_lsb +: 32] = m_rdata;
                beat_d  = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_ct      = ct_q;
    assign res_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_job_sequencer
//
// Drives aes_job_sequencer against a small picoaes register model. The model
// holds key/plaintext registers, reports "done" on STATUS after a chosen
// number of polls (or never), and returns a ciphertext from a lookup of the
// known test vectors (other key/plaintext pairs return key ^ pt).
// -----------------------------------------------------------------------------
module tb_aes_job_sequencer;

    localparam int POLL_LIMIT = 16;

    localparam logic [127:0] K1 = 128'hfb0b38bcad60b76c73377dfd9ce5692f;
    localparam logic [127:0] P1 = 128'h16b576b600a49804d81267644b80e292;
    localparam logic [127:0] C1 = 128'h33b661a74d164dc7b811f54fe5a5832c;
    localparam logic [127:0] P2 = 128'hfb8587bdac1c369369173bceb2ed4785;
    localparam logic [127:0] C2 = 128'h2287d7fc410a4e2059c15b4a2a2b3375;
    localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;

    // Full job latency (accept -> res_valid) when done is seen on the first poll.
    localparam int LAT_MISS = 18;
`ifdef AES_SEQ_KEYCACHE_EN
    localparam int LAT_HIT  = 14;
    localparam int KW_HIT   = 0;
`else
    localparam int LAT_HIT  = 18;
    localparam int KW_HIT   = 4;
`endif

    // ---------------------------------------------------------------- signals
    logic         clk;
    logic         resetn;
    logic         job_valid;
    logic         job_ready;
    logic [127:0] job_key;
    logic [127:0] job_pt;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_ct;
    logic         res_err;
    logic         m_valid;
    logic         m_wen;
    logic [6:0]   m_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic [2:0]   dbg_state;

    aes_job_sequencer #(.POLL_LIMIT(POLL_LIMIT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_key     (job_key),
        .job_pt      (job_pt),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_ct      (res_ct),
        .res_err     (res_err),
        .m_valid     (m_valid),
        .m_wen       (m_wen),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .dbg_state_o (dbg_state)
    );

    // -------------------------------------------------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------- picoaes model
    logic [31:0]  mreg [0:15];
    int           polls_seen = 0;
    int           done_after = 0;
    bit           stuck      = 1'b0;
    logic [127:0] mdl_key, mdl_pt, mdl_ct;

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        if (k == K1 && p == P1) return C1;
        if (k == K1 && p == P2) return C2;
        return k ^ p;
    endfunction

    always @(posedge clk) begin
        if (m_valid && m_wen) begin
            if (m_addr <= 7'h20) mreg[m_addr[5:2]] <= m_wdata;
            if (m_addr == 7'h00) polls_seen <= 0;
        end
        if (m_valid && !m_wen && m_addr == 7'h44) polls_seen <= polls_seen + 1;
    end

    always_comb begin
        mdl_key = {mreg[1], mreg[2], mreg[3], mreg[4]};
        mdl_pt  = {mreg[5], mreg[6], mreg[7], mreg[8]};
        mdl_ct  = aes_ref(mdl_key, mdl_pt);
        m_rdata = 32'h0;
        case (m_addr)
            7'h44: m_rdata = {31'h0, (!stuck && polls_seen >= done_after)};
            7'h40: m_rdata = mdl_ct[31:0];
            7'h3C: m_rdata = mdl_ct[63:32];
            7'h38: m_rdata = mdl_ct[95:64];
            7'h34: m_rdata = mdl_ct[127:96];
            default: m_rdata = 32'h0;
        endcase
    end

    // ------------------------------------------------------------- monitor
    int          kw_cnt   = 0;   // writes to key registers 0x04..0x10
    int          poll_cnt = 0;   // STATUS reads
    int          rd_cnt   = 0;   // CT reads 0x34..0x40
    int          acc_cnt  = 0;   // any bus access
    bit          trace_on = 1'b0;
    logic [39:0] bus_q[$];       // {wen, addr, wdata}

    always @(negedge clk) begin
        if (m_valid) begin
            acc_cnt++;
            if (m_wen && m_addr >= 7'h04 && m_addr <= 7'h10) kw_cnt++;
            if (!m_wen && m_addr == 7'h44) poll_cnt++;
            if (!m_wen && m_addr >= 7'h34 && m_addr <= 7'h40) rd_cnt++;
            if (trace_on) bus_q.push_back({m_wen, m_addr, m_wdata});
        end
    end

    // ---------------------------------------------------------- scoreboard
    int          n_checks = 0;
    int          n_err    = 0;
    logic [39:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------- driver tasks
    int kw_base, poll_base, rd_base;

    task automatic start_job(input logic [127:0] k, input logic [127:0] p,
                             input int da, input bit st);
        @(negedge clk);
        done_after = da;
        stuck      = st;
        kw_base    = kw_cnt;
        poll_base  = poll_cnt;
        rd_base    = rd_cnt;
        job_key    = k;
        job_pt     = p;
        job_valid  = 1'b1;
        chk("job_ready_idle", job_ready, 1);
        @(posedge clk);             // accept edge = cycle 0
        @(negedge clk);             // cycle 1
        job_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (res_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (res_valid !== 1'b1) chk("result_timeout", res_valid, 1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("job_ready_back", job_ready, 1);
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        int           done_after;
        bit           stuck;
        logic [127:0] exp_ct;
        bit           exp_err;
        int           exp_kw;
        int           exp_lat;
        int           exp_polls;
        int           exp_rd;
    } vec_t;

    vec_t vecs[6];

    // ------------------------------------------------------------------ test
    initial begin
        int lat;
        int busy_hi;
        int acc_before;
        logic [39:0] act;
        logic [39:0] exp;

        // Cache state entering each row: K1 (from job 1) for row 0.
        vecs[0] = '{key:K1, pt:P2, done_after:2, stuck:1'b0, exp_ct:C2, exp_err:1'b0,
                    exp_kw:KW_HIT, exp_lat:LAT_HIT + 2, exp_polls:3, exp_rd:4};
        vecs[1] = '{key:K2, pt:P1, done_after:1, stuck:1'b0, exp_ct:K2 ^ P1, exp_err:1'b0,
                    exp_kw:4, exp_lat:LAT_MISS + 1, exp_polls:2, exp_rd:4};
        vecs[2] = '{key:K2, pt:P2, done_after:0, stuck:1'b0, exp_ct:K2 ^ P2, exp_err:1'b0,
                    exp_kw:KW_HIT, exp_lat:LAT_HIT, exp_polls:1, exp_rd:4};
        // Timeout: 16 polls in cycles 13..28, RESP at 29.
        vecs[3] = '{key:K1, pt:P1, done_after:0, stuck:1'b1, exp_ct:128'h0, exp_err:1'b1,
                    exp_kw:4, exp_lat:29, exp_polls:16, exp_rd:0};
        // Timeout invalidated the cache, so K1 must be written again.
        vecs[4] = '{key:K1, pt:P1, done_after:5, stuck:1'b0, exp_ct:C1, exp_err:1'b0,
                    exp_kw:4, exp_lat:LAT_MISS + 5, exp_polls:6, exp_rd:4};
        vecs[5] = '{key:K1, pt:P2, done_after:0, stuck:1'b0, exp_ct:C2, exp_err:1'b0,
                    exp_kw:KW_HIT, exp_lat:LAT_HIT, exp_polls:1, exp_rd:4};

        // ---- reset
        resetn    = 1'b0;
        job_valid = 1'b0;
        job_key   = '0;
        job_pt    = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_ct",    res_ct,    0);
        chk("rst_res_err",   res_err,   0);
        chk("rst_m_valid",   m_valid,   0);
        chk("rst_m_wen",     m_wen,     0);
        chk("rst_m_addr",    m_addr,    0);
        chk("rst_m_wdata",   m_wdata,   0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_job_ready", job_ready, 1);

        // ---- job 1 with full bus trace
        trace_on = 1'b1;
        start_job(K1, P1, 3, 1'b0);
        wait_result(lat);
        trace_on = 1'b0;
        chk("j1_lat", lat, LAT_MISS + 3);
        chk("j1_ct",  res_ct, C1);
        chk("j1_err", res_err, 0);
        consume();

        exp_q.push_back({1'b1, 7'h10, K1[31:0]});
        exp_q.push_back({1'b1, 7'h0C, K1[63:32]});
        exp_q.push_back({1'b1, 7'h08, K1[95:64]});
        exp_q.push_back({1'b1, 7'h04, K1[127:96]});
        exp_q.push_back({1'b1, 7'h20, P1[31:0]});
        exp_q.push_back({1'b1, 7'h1C, P1[63:32]});
        exp_q.push_back({1'b1, 7'h18, P1[95:64]});
        exp_q.push_back({1'b1, 7'h14, P1[127:96]});
        exp_q.push_back({1'b1, 7'h00, 32'h6});
        exp_q.push_back({1'b1, 7'h00, 32'h6});
        exp_q.push_back({1'b1, 7'h00, 32'h4});
        exp_q.push_back({1'b1, 7'h00, 32'h4});
        repeat (4) exp_q.push_back({1'b0, 7'h44, 32'h0});
        exp_q.push_back({1'b0, 7'h40, 32'h0});
        exp_q.push_back({1'b0, 7'h3C, 32'h0});
        exp_q.push_back({1'b0, 7'h38, 32'h0});
        exp_q.push_back({1'b0, 7'h34, 32'h0});
        chk("trace_len", bus_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++) begin
            act = bus_q[i];
            exp = exp_q[i];
            if (!exp[39]) act[31:0] = 32'h0;   // write data is don't-care on reads
            chk($sformatf("trace_%0d", i), act, exp);
        end

        // ---- table-driven jobs
        for (int i = 0; i < 6; i++) begin
            start_job(vecs[i].key, vecs[i].pt, vecs[i].done_after, vecs[i].stuck);
            wait_result(lat);
            chk($sformatf("v%0d_lat",   i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_ct",    i), res_ct, vecs[i].exp_ct);
            chk($sformatf("v%0d_err",   i), res_err, vecs[i].exp_err);
            chk($sformatf("v%0d_kw",    i), kw_cnt - kw_base, vecs[i].exp_kw);
            chk($sformatf("v%0d_polls", i), poll_cnt - poll_base, vecs[i].exp_polls);
            chk($sformatf("v%0d_rd",    i), rd_cnt - rd_base, vecs[i].exp_rd);
            consume();
        end

        // ---- held request while busy, and result backpressure for 10 cycles
        start_job(K1, P2, 0, 1'b0);
        job_key   = K2;
        job_pt    = P2;
        job_valid = 1'b1;
        busy_hi   = 0;
        lat       = 1;
        while (res_valid !== 1'b1 && lat < 200) begin
            if (job_ready) busy_hi++;
            @(negedge clk);
            lat++;
        end
        chk("bp_lat", lat, LAT_HIT);
        chk("bp_busy_ready", busy_hi, 0);
        for (int c = 0; c < 10; c++) begin
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_ct",    res_ct, C2);
            chk("bp_res_err",   res_err, 0);
            chk("bp_job_ready", job_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);             // back in IDLE, held request pending
        res_ready = 1'b0;
        chk("held_ready", job_ready, 1);
        done_after = 0;
        stuck      = 1'b0;
        kw_base    = kw_cnt;
        @(posedge clk);             // held request accepted
        @(negedge clk);
        job_valid = 1'b0;
        wait_result(lat);
        chk("held_lat", lat, LAT_MISS);
        chk("held_ct",  res_ct, K2 ^ P2);
        chk("held_kw",  kw_cnt - kw_base, 4);
        consume();

        // ---- reset pulse during POLL
        start_job(K2, P1, 0, 1'b1);
        repeat (15) @(negedge clk);  // cycle 16, polling
        resetn = 1'b0;
        #1;
        acc_before = acc_cnt;
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_ct",    res_ct,    0);
        chk("mid_rst_res_err",   res_err,   0);
        chk("mid_rst_m_valid",   m_valid,   0);
        chk("mid_rst_m_wen",     m_wen,     0);
        chk("mid_rst_m_addr",    m_addr,    0);
        chk("mid_rst_m_wdata",   m_wdata,   0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_bus", acc_cnt, acc_before);
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_idle",  job_ready, 1);
        chk("mid_rst_nores", res_valid, 0);
        start_job(K1, P1, 1, 1'b0);
        wait_result(lat);
        chk("post_rst_lat", lat, LAT_MISS + 1);
        chk("post_rst_ct",  res_ct, C1);
        chk("post_rst_err", res_err, 0);
        chk("post_rst_kw",  kw_cnt - kw_base, 4);
        consume();

        // ---- report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
